spi_controller: RTL and testbench

- SPI mode-0 initiator that drives the same 3-wire bus (nCS, SCLK, COPI) the on-chip SPI register peripheral consumes.
- Accepts register-write requests over a valid/ready handshake.
- Serialises each request as a 16-bit frame, MSB first: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
- Used as the bench/loopback driver and as the on-chip configuration master.

---
 rtl/spi_pkg.sv | 42 ++++
 rtl/spi_clk_div.sv | 47 ++++
 rtl/spi_controller.sv | 204 ++++++++++++++++++++
 tb/tb_spi_controller.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
//
// Shared definitions for the SPI initiator:
//   - frame geometry (16-bit frame: R/W bit, 7-bit address, 8-bit data)
//   - register map of the on-chip SPI register peripheral
//   - controller state enum
//   - buildFrame(): packs a request into the on-wire frame
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_FRAME_W = 16;
  localparam int SPI_ADDR_W  = 7;
  localparam int SPI_DATA_W  = 8;
  localparam int SPI_RW_BIT  = 15;

  localparam logic [SPI_ADDR_W-1:0] REG_EN_OUT_7_0  = 7'd0;
  localparam logic [SPI_ADDR_W-1:0] REG_EN_OUT_15_8 = 7'd1;
  localparam logic [SPI_ADDR_W-1:0] REG_EN_PWM_7_0  = 7'd2;
  localparam logic [SPI_ADDR_W-1:0] REG_EN_PWM_15_8 = 7'd3;
  localparam logic [SPI_ADDR_W-1:0] REG_PWM_DUTY    = 7'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCK_LO,
    ST_SCK_HI,
    ST_HOLD,
    ST_GAP
  } spiState_e;

  // A read frame carries zeros in the data field so the peripheral can
  // drive its reply without contention on the data bits.
  function automatic logic [SPI_FRAME_W-1:0] buildFrame(
    input logic                  write,
    input logic [SPI_ADDR_W-1:0] addr,
    input logic [SPI_DATA_W-1:0] data
  );
    return {write, addr, write ? data : {SPI_DATA_W{1'b0}}};
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// ---------------------------------------------------------------------------
// spi_clk_div
//
// Loadable down-counter that times every phase of the SPI controller.
// The counter is reloaded on each state entry and tick_o is high while the
// count sits at zero, i.e. on the last clk cycle of the current phase.
//
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   load_i     reload the counter with loadVal_i
//   loadVal_i  phase length minus one
//   tick_o     current phase expires on the next clk edge
// ---------------------------------------------------------------------------
module spi_clk_div #(
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] loadVal_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count down to zero and park there until the next reload.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = loadVal_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/spi_controller.sv
// ---------------------------------------------------------------------------
// spi_controller
//
// SPI mode-0 initiator for the on-chip SPI register peripheral. Each accepted
// request is sent as one 16-bit frame, MSB first:
//   bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
// nCS stays low for 34*HALF_PERIOD clk cycles with 16 SCLK rising edges,
// followed by CS_GAP cycles of nCS high before the next request is accepted.
//
// Build option: define SPI_CONTROLLER_READ_EN to enable read frames
// (req_write_i = 0) and the cipo_i read-back path. Without it every frame is
// a write, cipo_i is unused and rd_data_o is 0.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_valid_i/ready_o  request handshake
//   req_write_i        1 = write, 0 = read (read build only)
//   req_addr_i         register address
//   req_wdata_i        write data
//   done_o             one-cycle pulse on the first cycle after nCS rises
//   busy_o             frame or inter-frame gap in progress
//   rd_data_o          data returned by the last read
//   ncs_o, sclk_o, copi_o  SPI bus outputs (registered)
//   cipo_i             SPI serial data in
// ---------------------------------------------------------------------------
module spi_controller
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int CS_GAP      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [SPI_ADDR_W-1:0] req_addr_i,
  input  logic [SPI_DATA_W-1:0] req_wdata_i,
  output logic                  done_o,
  output logic                  busy_o,
  output logic [SPI_DATA_W-1:0] rd_data_o,
  output logic                  ncs_o,
  output logic                  sclk_o,
  output logic                  copi_o,
  input  logic                  cipo_i
);

  localparam int MaxPhase = (HALF_PERIOD > CS_GAP) ? HALF_PERIOD : CS_GAP;
  localparam int CntW     = $clog2(MaxPhase);

  spiState_e              state_q, state_d;
  logic [SPI_FRAME_W-1:0] shift_q, shift_d;
  logic [4:0]             edgeCnt_q, edgeCnt_d;
  logic                   ncs_q, ncs_d;
  logic                   sclk_q, sclk_d;
  logic                   copi_q, copi_d;
  logic                   done_q, done_d;
  logic                   frameWrite;
  logic                   accept;
  logic                   inFrame;
  logic                   tick;
  logic                   load;
  logic [CntW-1:0]        loadVal;

`ifdef SPI_CONTROLLER_READ_EN
  assign frameWrite = req_write_i;
`else
  assign frameWrite = 1'b1;
`endif

  assign accept = req_valid_i && (state_q == ST_IDLE);

  // A phase counter reload happens on every entry into a timed state; the
  // GAP phase uses its own length, all bus phases use HALF_PERIOD.
  assign load    = (state_d != state_q) && (state_d != ST_IDLE);
  assign loadVal = (state_d == ST_GAP) ? CntW'(CS_GAP - 1) : CntW'(HALF_PERIOD - 1);

  spi_clk_div #(
    .CNT_W(CntW)
  ) uClkDiv (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (load),
    .loadVal_i(loadVal),
    .tick_o   (tick)
  );

  // Next-state logic. The first SCK_LO after SETUP does not shift, so the
  // frame spends one extra half-period low before the first rising edge,
  // giving 34 half-periods of nCS low in total. Shifting happens only on
  // SCK_HI -> SCK_LO so copi changes on the falling SCLK edge.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    edgeCnt_d = edgeCnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SETUP;
          shift_d   = buildFrame(frameWrite, req_addr_i, req_wdata_i);
          edgeCnt_d = '0;
        end
      end
      ST_SETUP: begin
        if (tick) state_d = ST_SCK_LO;
      end
      ST_SCK_LO: begin
        if (tick) begin
          state_d   = ST_SCK_HI;
          edgeCnt_d = edgeCnt_q + 5'd1;
        end
      end
      ST_SCK_HI: begin
        if (tick) begin
          if (edgeCnt_q == 5'd16) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_SCK_LO;
            shift_d = {shift_q[SPI_FRAME_W-2:0], 1'b0};
          end
        end
      end
      ST_HOLD: begin
        if (tick) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they can be registered
  // and still line up with the state they belong to.
  always_comb begin
    inFrame = (state_d == ST_SETUP) || (state_d == ST_SCK_LO) ||
              (state_d == ST_SCK_HI) || (state_d == ST_HOLD);
    ncs_d   = !inFrame;
    sclk_d  = (state_d == ST_SCK_HI);
    copi_d  = inFrame && shift_d[SPI_RW_BIT];
    done_d  = (state_q == ST_HOLD) && (state_d == ST_GAP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      edgeCnt_q <= '0;
      ncs_q     <= 1'b1;
      sclk_q    <= 1'b0;
      copi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      edgeCnt_q <= edgeCnt_d;
      ncs_q     <= ncs_d;
      sclk_q    <= sclk_d;
      copi_q    <= copi_d;
      done_q    <= done_d;
    end
  end

  assign ncs_o       = ncs_q;
  assign sclk_o      = sclk_q;
  assign copi_o      = copi_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign req_ready_o = (state_q == ST_IDLE);

`ifdef SPI_CONTROLLER_READ_EN
  logic [1:0]            cipoSync_q;
  logic [SPI_DATA_W-1:0] rdShift_q;
  logic [SPI_DATA_W-1:0] rdData_q;
  logic                  isRead_q;

  // cipo is asynchronous to clk, so it is double-flopped. The reply bits
  // are taken on the last cycle of SCK_HI for rises 9..16, which leaves the
  // synchroniser a full half-period to settle after the peripheral's
  // falling-edge update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cipoSync_q <= '0;
      rdShift_q  <= '0;
      rdData_q   <= '0;
      isRead_q   <= 1'b0;
    end else begin
      cipoSync_q <= {cipoSync_q[0], cipo_i};
      if (accept) isRead_q <= !req_write_i;
      if ((state_q == ST_SCK_HI) && tick && (edgeCnt_q >= 5'd9)) begin
        rdShift_q <= {rdShift_q[SPI_DATA_W-2:0], cipoSync_q[1]};
      end
      if (done_d && isRead_q) rdData_q <= rdShift_q;
    end
  end

  assign rd_data_o = rdData_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{req_write_i, cipo_i};
  assign rd_data_o     = '0;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// ---------------------------------------------------------------------------
// tb_spi_controller
//
// Drives spi_controller with directed requests. A frame-level model derives
// every bus output from the cycle offset since acceptance and is compared
// against the DUT on each falling clock edge. A behavioural loopback
// peripheral decodes the bus into a register array and answers reads on
// cipo. A second instance with HALF_PERIOD=3 checks the shorter frame.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_controller;
  import spi_pkg::*;

  localparam int HALF      = 4;
  localparam int GAP       = 8;
  localparam int FRAME_CYC = 34 * HALF;
  localparam int TOTAL     = FRAME_CYC + GAP;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       reqValid, reqWrite, reqReady;
  logic [6:0] reqAddr;
  logic [7:0] reqWdata, rdData;
  logic       done, busy, nCs, sclk, copi, cipo;

  logic       v3, w3, ready3, done3, busy3, ncs3, sclk3, copi3;
  logic [6:0] a3;
  logic [7:0] d3, rd3;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  spi_controller #(.HALF_PERIOD(HALF), .CS_GAP(GAP)) dut (
    .clk_i(clock), .rst_ni(rst_n),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_write_i(reqWrite),
    .req_addr_i(reqAddr), .req_wdata_i(reqWdata),
    .done_o(done), .busy_o(busy), .rd_data_o(rdData),
    .ncs_o(nCs), .sclk_o(sclk), .copi_o(copi), .cipo_i(cipo)
  );

  spi_controller #(.HALF_PERIOD(3), .CS_GAP(GAP)) dut3 (
    .clk_i(clock), .rst_ni(rst_n),
    .req_valid_i(v3), .req_ready_o(ready3), .req_write_i(w3),
    .req_addr_i(a3), .req_wdata_i(d3),
    .done_o(done3), .busy_o(busy3), .rd_data_o(rd3),
    .ncs_o(ncs3), .sclk_o(sclk3), .copi_o(copi3), .cipo_i(1'b0)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Frame the peripheral should see for a request.
  function automatic logic [15:0] frameOf(input logic w, input logic [6:0] a, input logic [7:0] d);
`ifdef SPI_CONTROLLER_READ_EN
    return w ? {1'b1, a, d} : {1'b0, a, 8'h00};
`else
    return {1'b1, a, d};
`endif
  endfunction

  // Half-period index p: 0 = setup, 1..32 alternate low/high (even = high),
  // 33 = hold. Bit 15 is on the wire until the first fall after rise 1.
  function automatic logic expSclk(input int t);
    int p;
    p = t / HALF;
    return (p >= 2) && (p <= 32) && (p % 2 == 0);
  endfunction

  function automatic logic expCopi(input int t, input logic [15:0] f);
    int p, b;
    p = t / HALF;
    if (p <= 1) b = 15;
    else begin
      b = 15 - (p - 1) / 2;
      if (b < 0) b = 0;
    end
    return f[b];
  endfunction

  // ---- frame-level model ----
  logic [7:0]  cipoTable [0:127];
  int          modelT = -1;
  int          acceptCount = 0;
  logic [15:0] modelFrame = '0;
  logic [7:0]  pendRd = '0;
  logic [7:0]  expRd = '0;

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      modelT = -1;
      expRd  = '0;
    end else if (modelT < 0) begin
      if (reqValid) begin
        modelT     = 0;
        modelFrame = frameOf(reqWrite, reqAddr, reqWdata);
        pendRd     = cipoTable[reqAddr];
        acceptCount++;
      end
    end else if (modelT == TOTAL - 1) begin
      modelT = -1;
    end else begin
      modelT++;
      if (modelT == FRAME_CYC && !modelFrame[15]) expRd = pendRd;
    end
  end

  always @(negedge clock) begin : compareProc
    logic inFrame;
    inFrame = (modelT >= 0) && (modelT < FRAME_CYC);
    checkOutput("cyc_nCS",    32'(nCs),      32'(!inFrame));
    checkOutput("cyc_sclk",   32'(sclk),     32'(inFrame ? expSclk(modelT) : 1'b0));
    checkOutput("cyc_copi",   32'(copi),     32'(inFrame ? expCopi(modelT, modelFrame) : 1'b0));
    checkOutput("cyc_done",   32'(done),     32'(modelT == FRAME_CYC));
    checkOutput("cyc_busy",   32'(busy),     32'(modelT >= 0));
    checkOutput("cyc_ready",  32'(reqReady), 32'(modelT < 0));
    checkOutput("cyc_rdData", 32'(rdData),   32'(expRd));
  end

  // ---- loopback peripheral ----
  logic [15:0] perBits = '0;
  logic [15:0] lastFrame = '0;
  int          perCnt = 0;
  logic [7:0]  perRegs [0:127];
  logic        rdActive = 1'b0;
  logic [6:0]  rdAddr = '0;
  logic        cipoBit = 1'b0;

  assign cipo = cipoBit;

  always @(posedge sclk or posedge nCs) begin
    if (nCs) begin
      if (perCnt == 16) begin
        lastFrame = perBits;
        if (perBits[15]) perRegs[perBits[14:8]] = perBits[7:0];
      end
      perCnt   = 0;
      rdActive = 1'b0;
    end else begin
      perBits = {perBits[14:0], copi};
      perCnt++;
      if (perCnt == 8) begin
        rdActive = !perBits[7];
        rdAddr   = perBits[6:0];
      end
    end
  end

  always @(negedge sclk) begin
    if (!nCs && rdActive && perCnt >= 8 && perCnt < 16) cipoBit = cipoTable[rdAddr][15 - perCnt];
  end

  // ---- bus timing monitors ----
  int lowRun = 0, highRun = 0, lastLow = 0, lastHigh = 0, doneCount = 0;
  logic [7:0] rdAtDone = '0;
  int low3Run = 0, last3Low = 0, done3Count = 0;
  logic [15:0] bits3 = '0;

  always @(negedge clock) begin
    if (done) begin
      doneCount++;
      rdAtDone = rdData;
    end
    if (!nCs) begin
      lowRun++;
      if (highRun > 0) lastHigh = highRun;
      highRun = 0;
    end else begin
      if (lowRun > 0) lastLow = lowRun;
      lowRun = 0;
      highRun++;
    end
    if (done3) done3Count++;
    if (!ncs3) low3Run++;
    else begin
      if (low3Run > 0) last3Low = low3Run;
      low3Run = 0;
    end
  end

  always @(posedge sclk3) begin
    if (!ncs3) bits3 = {bits3[14:0], copi3};
  end

  // ---- stimulus ----
  task automatic applyStimulus(input logic w, input logic [6:0] a, input logic [7:0] d);
    int n;
    @(negedge clock);
    reqValid = 1'b1;
    reqWrite = w;
    reqAddr  = a;
    reqWdata = d;
    n = acceptCount;
    for (int i = 0; i < 3 * TOTAL && acceptCount == n; i++) @(negedge clock);
    if (acceptCount == n) begin
      errors++;
      $display("[TB] FAIL accept_timeout: request addr 0x%0h not accepted", a);
    end
    reqValid = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 3 * TOTAL && modelT >= 0; i++) @(negedge clock);
    checkOutput("idle_timeout", 32'(modelT < 0), 32'd1);
    repeat (2) @(negedge clock);
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    int dc, n;
    rst_n    = 1'b0;
    reqValid = 1'b0;
    reqWrite = 1'b1;
    reqAddr  = '0;
    reqWdata = '0;
    v3 = 1'b0; w3 = 1'b1; a3 = '0; d3 = '0;
    for (int i = 0; i < 128; i++) begin
      cipoTable[i] = '0;
      perRegs[i]   = '0;
    end
    repeat (3) @(negedge clock);
    checkOutput("rst_nCS",   32'(nCs),      32'd1);
    checkOutput("rst_sclk",  32'(sclk),     32'd0);
    checkOutput("rst_ready", 32'(reqReady), 32'd1);
    checkOutput("rst_rd",    32'(rdData),   32'd0);
    rst_n = 1'b1;

    $display("[TB] test 1: single write");
    applyStimulus(1'b1, REG_EN_OUT_7_0, 8'hA5);
    waitIdle();
    checkOutput("t1_frame", 32'(lastFrame), 32'h80A5);
    checkOutput("t1_nCsLow", 32'(lastLow), 32'd136);
    checkOutput("t1_doneCount", 32'(doneCount), 32'd1);
    checkOutput("t1_reg", 32'(perRegs[0]), 32'hA5);

    $display("[TB] test 2: back-to-back requests");
    @(negedge clock);
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = REG_PWM_DUTY; reqWdata = 8'h80;
    n = acceptCount;
    for (int i = 0; i < 3 * TOTAL && acceptCount == n; i++) @(negedge clock);
    reqAddr = REG_EN_PWM_7_0; reqWdata = 8'h0F;
    for (int i = 0; i < 3 * TOTAL && acceptCount < n + 2; i++) @(negedge clock);
    reqValid = 1'b0;
    checkOutput("t2_accepts", 32'(acceptCount - n), 32'd2);
    waitIdle();
    checkOutput("t2_gapHigh", 32'(lastHigh >= GAP), 32'd1);
    checkOutput("t2_pwmDuty", 32'(perRegs[4]), 32'h80);
    checkOutput("t2_enPwm", 32'(perRegs[2]), 32'h0F);
    checkOutput("t2_doneCount", 32'(doneCount), 32'd3);

    $display("[TB] test 3: reset mid-frame");
    applyStimulus(1'b1, REG_EN_OUT_15_8, 8'hFF);
    for (int i = 0; i < TOTAL && modelT != 41; i++) @(negedge clock);
    checkOutput("t3_reach", 32'(modelT), 32'd41);
    dc = doneCount;
    @(posedge clock);
    #2;
    checkOutput("t3_sclkHigh", 32'(sclk), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t3_nCsAsync", 32'(nCs), 32'd1);
    checkOutput("t3_sclkAsync", 32'(sclk), 32'd0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    waitIdle();
    checkOutput("t3_noDone", 32'(doneCount), 32'(dc));
    checkOutput("t3_regKept", 32'(perRegs[1]), 32'h00);
    applyStimulus(1'b1, REG_EN_OUT_15_8, 8'h3C);
    waitIdle();
    checkOutput("t3_regAfter", 32'(perRegs[1]), 32'h3C);

    $display("[TB] test 4: inputs change during frame");
    applyStimulus(1'b1, REG_EN_PWM_15_8, 8'h55);
    for (int i = 0; i < TOTAL && modelT >= 0 && modelT < TOTAL - 2; i++) begin
      reqValid = 1'b1;
      reqAddr  = 7'($urandom);
      reqWdata = 8'($urandom);
      reqWrite = 1'($urandom);
      @(negedge clock);
    end
    reqValid = 1'b0;
    reqWrite = 1'b1;
    waitIdle();
    checkOutput("t4_frame", 32'(lastFrame), 32'h8355);
    checkOutput("t4_reg", 32'(perRegs[3]), 32'h55);

    $display("[TB] test 5: HALF_PERIOD=3 instance");
    @(negedge clock);
    v3 = 1'b1; a3 = REG_PWM_DUTY; d3 = 8'h01;
    @(negedge clock);
    v3 = 1'b0;
    repeat (130) @(negedge clock);
    checkOutput("t5_nCsLow", 32'(last3Low), 32'd102);
    checkOutput("t5_frame", 32'(bits3), 32'h8401);
    checkOutput("t5_done", 32'(done3Count), 32'd1);
    checkOutput("t5_rd", 32'(rd3), 32'd0);

    $display("[TB] test 6: read request");
    cipoTable[3] = 8'h3C;
`ifdef SPI_CONTROLLER_READ_EN
    applyStimulus(1'b0, REG_EN_PWM_15_8, 8'hFF);
    waitIdle();
    checkOutput("t6_frame", 32'(lastFrame), 32'h0300);
    checkOutput("t6_rdAtDone", 32'(rdAtDone), 32'h3C);
    applyStimulus(1'b1, REG_EN_OUT_7_0, 8'h11);
    waitIdle();
    checkOutput("t6_rdKept", 32'(rdData), 32'h3C);
    checkOutput("t6_reg", 32'(perRegs[0]), 32'h11);
`else
    applyStimulus(1'b0, REG_EN_PWM_15_8, 8'h5A);
    waitIdle();
    checkOutput("t6_frameForcedWrite", 32'(lastFrame), 32'h835A);
    checkOutput("t6_rdZero", 32'(rdData), 32'h00);
    checkOutput("t6_reg", 32'(perRegs[3]), 32'h5A);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
